// File: rtl/hv_bist_pkg.sv
// Shared types and constants for the hv BIST sequencer: FSM states and
// result-word bit positions.
package hv_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABIST,
        ST_LBIST,
        ST_DONE
    } bist_state_t;

    localparam int RSLT_LBIST = 6;
    localparam int RSLT_TMO   = 7;
    localparam int RSLT_ABORT = 8;

    // Result word holds one pass bit per analog item plus lbist, timeout and abort.
    function automatic int RSLT_W(input int item_num);
        return item_num + 3;
    endfunction

endpackage

// File: rtl/hv_bist_ctrl_if.sv
// Request/engine/result signal bundle between the BIST sequencer and its
// neighbours. The sequencer connects through the slave modport.
interface hv_bist_ctrl_if #(
    parameter int BIST_ITEM_NUM = 6
);

    logic                                            i_bist_req;
    logic                                            o_bist_en;
    logic [BIST_ITEM_NUM-1:0]                        i_abist_status;
    logic                                            i_lbist_en;
    logic                                            o_lbist_start;
    logic                                            i_lbist_done;
    logic                                            i_lbist_pass;
    logic                                            o_bist_busy;
    logic                                            o_bist_done;
    logic                                            o_bist_fail;
    logic [hv_bist_pkg::RSLT_W(BIST_ITEM_NUM)-1:0]   o_bist_rslt;

    modport slave (
        input  i_bist_req, i_abist_status, i_lbist_en, i_lbist_done, i_lbist_pass,
        output o_bist_en, o_lbist_start, o_bist_busy, o_bist_done, o_bist_fail, o_bist_rslt
    );

    modport master (
        output i_bist_req, i_abist_status, i_lbist_en, i_lbist_done, i_lbist_pass,
        input  o_bist_en, o_lbist_start, o_bist_busy, o_bist_done, o_bist_fail, o_bist_rslt
    );

endinterface

// File: rtl/hv_bist_tmo_cnt.sv
// Saturating phase-timeout counter; expire is high once the count reaches
// the supplied limit and stays high until cleared.
module hv_bist_tmo_cnt #(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] lim,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = (cnt >= lim);

endmodule

// File: rtl/hv_bist_ctrl.sv
// Sequencer for the hv analog BIST engine followed by logic BIST: enables
// the engine, launches lbist on hand-off, and latches the consolidated result.
module hv_bist_ctrl
    import hv_bist_pkg::*;
#(
    parameter int CLK_M         = 48,
    parameter int BIST_ITEM_NUM = 6,
    parameter int ABIST_TMO_US  = 200,
    parameter int LBIST_TMO_US  = 500
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    hv_bist_ctrl_if.slave   bus
);

    localparam int RW            = RSLT_W(BIST_ITEM_NUM);
    localparam int ABIST_TMO_CYC = ABIST_TMO_US * CLK_M;
    localparam int LBIST_TMO_CYC = LBIST_TMO_US * CLK_M;
    localparam int MAX_TMO_CYC   = (ABIST_TMO_CYC > LBIST_TMO_CYC) ? ABIST_TMO_CYC : LBIST_TMO_CYC;
    localparam int CNT_W         = $clog2(MAX_TMO_CYC + 1);

    bist_state_t   state, state_nxt;
    logic          req_d;
    logic          start;
    logic          abort;
    logic          expire;
    logic          cnt_clr;
    logic [CNT_W-1:0] cnt_lim;

    logic          bist_en, bist_en_nxt;
    logic          lbist_start, lbist_start_nxt;
    logic          busy, busy_nxt;
    logic          done, done_nxt;
    logic          fail, fail_nxt;
    logic [RW-1:0] rslt, rslt_nxt;

    function automatic logic fail_of(input logic [RW-1:0] r);
        return ~&r[BIST_ITEM_NUM-1:0] | ~r[RSLT_LBIST] | r[RSLT_TMO];
    endfunction

    assign start = bus.i_bist_req & ~req_d;

    // Counter restarts on every phase change and is held clear outside the timed phases.
    assign cnt_clr = (state_nxt != state) || (state == ST_IDLE) || (state == ST_DONE);
    assign cnt_lim = (state == ST_LBIST) ? CNT_W'(LBIST_TMO_CYC - 1) : CNT_W'(ABIST_TMO_CYC - 1);

    hv_bist_tmo_cnt #(
        .CNT_W (CNT_W)
    ) u_tmo_cnt (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clr    (cnt_clr),
        .lim    (cnt_lim),
        .expire (expire)
    );

    always_comb begin
        state_nxt       = state;
        bist_en_nxt     = bist_en;
        lbist_start_nxt = 1'b0;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        fail_nxt        = fail;
        rslt_nxt        = rslt;
        abort           = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_ABIST;
                    rslt_nxt    = '0;
                    fail_nxt    = 1'b0;
                    bist_en_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            ST_ABIST: begin
                if (!bus.i_bist_req) begin
                    abort = 1'b1;
                end else if (bus.i_lbist_en) begin
                    rslt_nxt[BIST_ITEM_NUM-1:0] = bus.i_abist_status;
                    lbist_start_nxt             = 1'b1;
                    state_nxt                   = ST_LBIST;
                end else if (expire) begin
                    rslt_nxt[BIST_ITEM_NUM-1:0] = bus.i_abist_status;
                    rslt_nxt[RSLT_TMO]          = 1'b1;
                    state_nxt                   = ST_DONE;
                end
            end
            ST_LBIST: begin
                if (!bus.i_bist_req) begin
                    abort = 1'b1;
                end else if (bus.i_lbist_done) begin
                    rslt_nxt[RSLT_LBIST] = bus.i_lbist_pass;
                    state_nxt            = ST_DONE;
                end else if (expire) begin
                    rslt_nxt[RSLT_TMO]   = 1'b1;
                    rslt_nxt[RSLT_LBIST] = 1'b0;
                    state_nxt            = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.i_bist_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (abort) begin
            state_nxt            = ST_IDLE;
            bist_en_nxt          = 1'b0;
            busy_nxt             = 1'b0;
            rslt_nxt[RSLT_ABORT] = 1'b1;
            fail_nxt             = 1'b1;
        end

        if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
            bist_en_nxt = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
            fail_nxt    = fail_of(rslt_nxt);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            req_d       <= 1'b0;
            bist_en     <= 1'b0;
            lbist_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            rslt        <= '0;
        end else begin
            state       <= state_nxt;
            req_d       <= bus.i_bist_req;
            bist_en     <= bist_en_nxt;
            lbist_start <= lbist_start_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            fail        <= fail_nxt;
            rslt        <= rslt_nxt;
        end
    end

    assign bus.o_bist_en     = bist_en;
    assign bus.o_lbist_start = lbist_start;
    assign bus.o_bist_busy   = busy;
    assign bus.o_bist_done   = done;
    assign bus.o_bist_fail   = fail;
    assign bus.o_bist_rslt   = rslt;

endmodule

// File: tb/tb_hv_bist_ctrl.sv
// Bench for hv_bist_ctrl: timed stimulus per run, outcome predicted from the
// phase/priority rules and checked by a monitor at the end of every run.
module tb_hv_bist_ctrl;

    localparam int N         = 6;
    localparam int CLK_M     = 48;
    localparam int ABIST_CYC = 200 * CLK_M;
    localparam int LBIST_CYC = 500 * CLK_M;
    localparam int INF       = 32'h7fffffff;

    typedef struct {
        logic [8:0] rslt;
        logic       fail;
        logic       done;
        int         starts;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hv_bist_ctrl_if #(.BIST_ITEM_NUM(N)) bus ();

    hv_bist_ctrl #(
        .CLK_M        (CLK_M),
        .BIST_ITEM_NUM(N),
        .ABIST_TMO_US (200),
        .LBIST_TMO_US (500)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome of one run. Times are in clock edges after the request edge (edge 0):
    // the analog phase decides on edges 1.., the logic phase (entered at edge a+1)
    // decides on edges a+2..; t_end is the edge after which busy is low.
    function automatic exp_t model(input logic [5:0] status, input int a, input int d,
                                   input logic pass, input int ab, output int t_end);
        exp_t e;
        int kab, kl, jab, jd;
        e.rslt = '0; e.fail = 1'b1; e.done = 1'b0; e.starts = 0;
        kab = (ab >= 1) ? ab - 1 : INF;
        kl  = (a >= 0) ? a : INF;
        if (kab <= kl && kab <= ABIST_CYC - 1) begin
            e.rslt[8] = 1'b1;
            t_end = ab;
        end else if (kl <= ABIST_CYC - 1) begin
            e.rslt[5:0] = status;
            e.starts = 1;
            jab = (ab >= 0) ? ab - (a + 2) : INF;
            jd  = (d >= 0) ? d : INF;
            if (jab <= jd && jab <= LBIST_CYC - 1) begin
                e.rslt[8] = 1'b1;
                t_end = ab;
            end else if (jd <= LBIST_CYC - 1) begin
                e.rslt[6] = pass;
                e.done = 1'b1;
                e.fail = (status != 6'h3F) || !pass;
                t_end = a + 2 + d;
            end else begin
                e.rslt[7] = 1'b1;
                e.done = 1'b1;
                t_end = a + 2 + LBIST_CYC - 1;
            end
        end else begin
            e.rslt[5:0] = status;
            e.rslt[7] = 1'b1;
            e.done = 1'b1;
            t_end = ABIST_CYC;
        end
        return e;
    endfunction

    // a: analog cycle in which lbist_en is first seen (-1 never); d: logic cycle of
    // the done pulse (-1 never); ab: edge at which req is seen low (-1 never).
    task automatic run(input logic [5:0] status, input int a, input int d,
                       input logic pass, input int ab);
        exp_t e;
        int t_end;
        e = model(status, a, d, pass, ab, t_end);
        @(posedge clk); #1;
        bus.i_abist_status = status;
        bus.i_lbist_en     = 1'b0;
        bus.i_lbist_done   = 1'b0;
        bus.i_lbist_pass   = pass;
        bus.i_bist_req     = 1'b1;
        chk("en_before_edge", 32'(bus.o_bist_en), 0);
        sb_q.push_back(e);
        @(posedge clk); #1;
        chk("en_latency",   32'(bus.o_bist_en), 1);
        chk("busy_latency", 32'(bus.o_bist_busy), 1);
        chk("rslt_cleared", 32'(bus.o_bist_rslt), 0);
        chk("fail_cleared", 32'(bus.o_bist_fail), 0);
        for (int t = 1; t <= t_end + 2; t++) begin
            bus.i_lbist_en   = (a >= 0) && (t >= a + 1);
            bus.i_lbist_done = (d >= 0) && (t == a + 2 + d);
            if (ab >= 1 && t >= ab) bus.i_bist_req = 1'b0;
            @(posedge clk); #1;
            if (t == t_end - 1) chk("busy_before_end", 32'(bus.o_bist_busy), 1);
            if (t == t_end) begin
                chk("busy_at_end", 32'(bus.o_bist_busy), 0);
                chk("en_at_end",   32'(bus.o_bist_en), 0);
            end
        end
        if (ab < 0) begin
            repeat (5) @(posedge clk);
            #1;
            chk("no_retrigger_busy", 32'(bus.o_bist_busy), 0);
            chk("no_retrigger_en",   32'(bus.o_bist_en), 0);
        end
        bus.i_bist_req   = 1'b0;
        bus.i_lbist_en   = 1'b0;
        bus.i_lbist_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Monitor: a run ends when busy falls; result, fail, done pulse and
    // lbist_start count are compared against the oldest prediction.
    logic busy_q = 1'b0;
    int   starts = 0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_lbist_start === 1'b1) starts++;
        if (busy_q === 1'b1 && bus.o_bist_busy === 1'b0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_end", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_rslt",   32'(bus.o_bist_rslt), 32'(e.rslt));
                chk("sb_fail",   32'(bus.o_bist_fail), 32'(e.fail));
                chk("sb_done",   32'(bus.o_bist_done), 32'(e.done));
                chk("sb_starts", 32'(starts), 32'(e.starts));
            end
            starts = 0;
        end else if (bus.o_bist_done === 1'b1) begin
            chk("spurious_done", 1, 0);
        end
        busy_q = bus.o_bist_busy;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t z;
        logic [5:0] st;
        int a, d, ab;
        bus.i_bist_req = 1'b0;
        bus.i_abist_status = '0;
        bus.i_lbist_en = 1'b0;
        bus.i_lbist_done = 1'b0;
        bus.i_lbist_pass = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en",    32'(bus.o_bist_en), 0);
        chk("rst_start", 32'(bus.o_lbist_start), 0);
        chk("rst_busy",  32'(bus.o_bist_busy), 0);
        chk("rst_done",  32'(bus.o_bist_done), 0);
        chk("rst_fail",  32'(bus.o_bist_fail), 0);
        chk("rst_rslt",  32'(bus.o_bist_rslt), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run(6'h3F, 3000, 1000, 1'b1, -1);            // nominal pass -> 0x07F
        run(6'h2F, -1, -1, 1'b1, -1);                // analog timeout -> 0x0AF
        run(6'h3F, 5, -1, 1'b1, -1);                 // logic timeout
        run(6'h3F, 5, LBIST_CYC - 1, 1'b1, -1);      // done in the timeout cycle
        run(6'h15, ABIST_CYC - 1, 3, 1'b1, -1);      // lbist_en in the timeout cycle
        run(6'h3F, 10, 100, 1'b1, 30);               // abort during logic phase
        run(6'h3F, 20, 5, 1'b0, -1);                 // logic fail verdict

        for (int i = 0; i < 10; i++) begin
            st = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom);
            a  = $urandom_range(0, 40);
            d  = $urandom_range(0, 40);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, a + d + 4) : -1;
            run(st, a, d, 1'($urandom), ab);
        end

        // Reset in the middle of the analog phase.
        @(posedge clk); #1;
        bus.i_abist_status = 6'h3F;
        bus.i_bist_req = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(bus.o_bist_busy), 1);
        z.rslt = '0; z.fail = 1'b0; z.done = 1'b0; z.starts = 0;
        sb_q.push_back(z);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en",    32'(bus.o_bist_en), 0);
        chk("async_rst_busy",  32'(bus.o_bist_busy), 0);
        chk("async_rst_start", 32'(bus.o_lbist_start), 0);
        chk("async_rst_done",  32'(bus.o_bist_done), 0);
        chk("async_rst_fail",  32'(bus.o_bist_fail), 0);
        chk("async_rst_rslt",  32'(bus.o_bist_rslt), 0);
        bus.i_bist_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
